data_mem_responder: RTL



---
 rtl/data_mem_pkg.sv | 26 ++
 rtl/data_mem_array.sv | 49 ++++
 rtl/data_mem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder: bus widths, FSM states,
// reset contents of the word array and the address legality check.
package data_mem_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // With init_desc set, the first ten words hold a descending run 10..1 for the sort initiator
    function automatic logic [DATA_W-1:0] init_word(input int k, input int init_desc);
        if (init_desc != 0 && k < 10) begin
            return DATA_W'(10 - k);
        end
        return '0;
    endfunction

    function automatic logic addr_error(input logic [ADDR_W-1:0] addr, input int depth);
        return (addr[2:0] != 3'b000) || (addr >= ADDR_W'(depth * 8));
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Doubleword storage with reset-time init contents, one write port and combinational
// read/observation taps. Optional per-byte write strobes under DATA_MEM_BYTE_EN.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int INIT_DESC = 1,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [DATA_W-1:0]   wr_data,
`ifdef DATA_MEM_BYTE_EN
    input  logic [7:0]          wr_strb,
`endif
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rd_data,
    output logic [8*DATA_W-1:0] obs
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= init_word(k, INIT_DESC);
            end
        end else if (wr_en) begin
`ifdef DATA_MEM_BYTE_EN
            for (int b = 0; b < 8; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
`else
            mem[wr_idx] <= wr_data;
`endif
        end
    end

    assign rd_data = mem[rd_idx];

    for (genvar k = 0; k < 8; k++) begin : g_obs
        assign obs[k*DATA_W +: DATA_W] = mem[k];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the data-memory request interface: handshake FSM, fixed-latency
// response and address decode. Build with DATA_MEM_BYTE_EN for byte write strobes.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int READ_LAT  = 1,
    parameter int INIT_DESC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef DATA_MEM_BYTE_EN
    input  logic [7:0]        req_wstrb,
`endif
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DATA_W-1:0] A1,
    output logic [DATA_W-1:0] A2,
    output logic [DATA_W-1:0] A3,
    output logic [DATA_W-1:0] A4,
    output logic [DATA_W-1:0] A5,
    output logic [DATA_W-1:0] A6,
    output logic [DATA_W-1:0] A7,
    output logic [DATA_W-1:0] A8
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam bit         DIRECT   = (READ_LAT == 1);
    localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

    state_t            state;
    logic [2:0]        cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
`ifdef DATA_MEM_BYTE_EN
    logic [7:0]        lat_wstrb;
    logic [7:0]        cur_wstrb;
`endif

    logic              handshake;
    logic              go_resp;
    logic              cur_write;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_err;
    logic [IDX_W-1:0]  cur_idx;
    logic              mem_we;
    logic [DATA_W-1:0] rd_data;
    logic [8*DATA_W-1:0] obs;

    assign handshake = req_valid && req_ready;

    // With single-cycle latency the RESP-entry edge is the handshake edge itself,
    // so the live request is used in IDLE and the latched copy everywhere else.
    always_comb begin
        cur_write = lat_write;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
`ifdef DATA_MEM_BYTE_EN
        cur_wstrb = lat_wstrb;
`endif
        if (state == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
`ifdef DATA_MEM_BYTE_EN
            cur_wstrb = req_wstrb;
`endif
        end
    end

    assign go_resp = (state == IDLE && handshake && DIRECT) || (state == WAIT && cnt == 3'd1);
    assign cur_err = addr_error(cur_addr, DEPTH);
    assign cur_idx = cur_addr[IDX_W+2:3];
    assign mem_we  = go_resp && cur_write && !cur_err;

    data_mem_array #(
        .DEPTH     (DEPTH),
        .INIT_DESC (INIT_DESC)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_we),
        .wr_idx  (cur_idx),
        .wr_data (cur_wdata),
`ifdef DATA_MEM_BYTE_EN
        .wr_strb (cur_wstrb),
`endif
        .rd_idx  (cur_idx),
        .rd_data (rd_data),
        .obs     (obs)
    );

    // cnt counts remaining WAIT cycles; leaving at 1 lands RESP on the READ_LAT-th cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifdef DATA_MEM_BYTE_EN
            lat_wstrb <= '0;
`endif
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
`ifdef DATA_MEM_BYTE_EN
                        lat_wstrb <= req_wstrb;
`endif
                        req_ready <= 1'b0;
                        if (DIRECT) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
            if (go_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_err || cur_write) ? '0 : rd_data;
            end
        end
    end

    assign A1 = obs[0*DATA_W +: DATA_W];
    assign A2 = obs[1*DATA_W +: DATA_W];
    assign A3 = obs[2*DATA_W +: DATA_W];
    assign A4 = obs[3*DATA_W +: DATA_W];
    assign A5 = obs[4*DATA_W +: DATA_W];
    assign A6 = obs[5*DATA_W +: DATA_W];
    assign A7 = obs[6*DATA_W +: DATA_W];
    assign A8 = obs[7*DATA_W +: DATA_W];

endmodule
